// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC issue, response capture, tagged FIFO to decode
// Absorbs the instruction memory's one-cycle latency and post-reset priming response.
module fetch_unit #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [31:0] PC,
    input  logic [31:0] instr,
    input  logic        stop,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        fetch_done
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {S_PRIME, S_FETCH, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q;
    logic [31:0]     rsp_pc;
    logic            pend;
    logic [31:0]     fifo_instr [DEPTH];
    logic [31:0]     fifo_pc    [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    logic in_range, has_room, capture, push, stop_cap, pop, issue;

    // count ignores any same-edge pop so the memory response can never overflow the FIFO
    always_comb begin
        in_range = (pc_q <= LAST_PC);
        has_room = ((count + {{AW{1'b0}}, pend}) < (AW+1)'(DEPTH));
        capture  = pend && !redirect_valid;
        push     = capture && !stop;
        stop_cap = capture && stop;
        pop      = out_valid && out_ready && !redirect_valid;
        issue    = (state_q == S_FETCH) && !redirect_valid && !stop_cap && in_range && has_room;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PRIME: state_d = S_FETCH;
            S_FETCH: if (stop_cap || !in_range) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_PRIME;
        endcase
        if (redirect_valid) state_d = S_FETCH;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_PRIME;
            pc_q    <= RESET_PC;
            rsp_pc  <= '0;
            pend    <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                pc_q   <= redirect_pc;
                pend   <= 1'b0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                pend <= issue;
                if (issue) begin
                    rsp_pc <= pc_q;
                    pc_q   <= pc_q + 32'd4;
                end else if (stop_cap) begin
                    pc_q <= rsp_pc;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    // storage needs no reset; the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= instr;
            fifo_pc[wr_ptr]    <= rsp_pc;
        end
    end

    assign PC         = pc_q;
    assign out_valid  = (count != '0);
    assign out_instr  = out_valid ? fifo_instr[rd_ptr] : 32'h0;
    assign out_pc     = out_valid ? fifo_pc[rd_ptr] : 32'h0;
    assign fetch_done = (state_q == S_DONE);
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with an instruction memory model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] PC, instr, redirect_pc, out_instr, out_pc;
    logic        stop, redirect_valid, out_valid, out_ready, fetch_done;
    logic [31:0] pc2, instr2, out_instr2, out_pc2;
    logic        stop2, out_valid2, fetch_done2;

    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0), .MEM_BYTES(1024)) dut (
        .clk(clk), .rstn(rstn), .PC(PC), .instr(instr), .stop(stop),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .fetch_done(fetch_done)
    );

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0), .MEM_BYTES(32)) dut2 (
        .clk(clk), .rstn(rstn), .PC(pc2), .instr(instr2), .stop(stop2),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(out_valid2), .out_instr(out_instr2), .out_pc(out_pc2),
        .out_ready(1'b1), .fetch_done(fetch_done2)
    );

    // registered instruction memory, one per requester
    always @(posedge clk) begin
        instr  <= mem[PC[9:2]];
        stop   <= (mem[PC[9:2]] == 32'h0);
        instr2 <= mem[pc2[9:2]];
        stop2  <= (mem[pc2[9:2]] == 32'h0);
    end

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] opc;
        logic [31:0] oinstr;
        logic        done;
        logic [31:0] pc2;
        logic        done2;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        if (i == 0) return 32'h00000013;
        if (i == 1) return 32'h00100093;
        return 32'h00000013 + (32'(i) << 8);
    endfunction

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic reset_dut(input logic rdy);
        rstn = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc = t;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_table();
        for (int i = 0; i < 12; i++) begin
            wait_edges(1);
            chk($sformatf("tbl%0d_pc", i), PC, tbl[i].pc);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_done", i), fetch_done, tbl[i].done);
            chk($sformatf("tbl%0d_pc2", i), pc2, tbl[i].pc2);
            chk($sformatf("tbl%0d_done2", i), fetch_done2, tbl[i].done2);
            chk($sformatf("tbl%0d_valid2", i), out_valid2, tbl[i].valid);
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d_opc", i), out_pc, tbl[i].opc);
                chk($sformatf("tbl%0d_oinstr", i), out_instr, tbl[i].oinstr);
                chk($sformatf("tbl%0d_opc2", i), out_pc2, tbl[i].opc);
                chk($sformatf("tbl%0d_oinstr2", i), out_instr2, tbl[i].oinstr);
            end
        end
    endtask

    initial begin
        logic [31:0] exp_pc, prev_pc, prev_instr;
        logic        prev_hold, live;
        int          n;

        for (int i = 0; i < 256; i++) mem[i] = word_of(i);
        mem[8] = 32'h0;

        // edge-by-edge expectations after reset release; E1 is index 0
        tbl[0]  = '{32'h00, 1'b0, 32'h00, 32'h0,      1'b0, 32'h00, 1'b0};
        tbl[1]  = '{32'h04, 1'b0, 32'h00, 32'h0,      1'b0, 32'h04, 1'b0};
        tbl[2]  = '{32'h08, 1'b1, 32'h00, word_of(0), 1'b0, 32'h08, 1'b0};
        tbl[3]  = '{32'h0C, 1'b1, 32'h04, word_of(1), 1'b0, 32'h0C, 1'b0};
        tbl[4]  = '{32'h10, 1'b1, 32'h08, word_of(2), 1'b0, 32'h10, 1'b0};
        tbl[5]  = '{32'h14, 1'b1, 32'h0C, word_of(3), 1'b0, 32'h14, 1'b0};
        tbl[6]  = '{32'h18, 1'b1, 32'h10, word_of(4), 1'b0, 32'h18, 1'b0};
        tbl[7]  = '{32'h1C, 1'b1, 32'h14, word_of(5), 1'b0, 32'h1C, 1'b0};
        tbl[8]  = '{32'h20, 1'b1, 32'h18, word_of(6), 1'b0, 32'h20, 1'b0};
        tbl[9]  = '{32'h24, 1'b1, 32'h1C, word_of(7), 1'b0, 32'h20, 1'b1};
        tbl[10] = '{32'h20, 1'b0, 32'h00, 32'h0,      1'b1, 32'h20, 1'b1};
        tbl[11] = '{32'h20, 1'b0, 32'h00, 32'h0,      1'b1, 32'h20, 1'b1};

        rstn = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_opc", out_pc, 32'h0);
        chk("rst_done", fetch_done, 1'b0);

        reset_dut(1'b1);
        run_table();

        // async reset with three entries buffered
        reset_dut(1'b0);
        wait_edges(5);
        chk("ar_pre_valid", out_valid, 1'b1);
        rstn = 1'b0;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_pc", PC, 32'h0);
        @(negedge clk);
        out_ready = 1'b1;
        rstn = 1'b1;
        run_table();

        // backpressure: FIFO fills to 4, then drains gap-free
        reset_dut(1'b0);
        wait_edges(12);
        chk("bp_pc", PC, 32'h10);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_head", out_pc, 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bp_beat%0d_valid", k), out_valid, 1'b1);
            chk($sformatf("bp_beat%0d_pc", k), out_pc, 32'(k * 4));
            wait_edges(1);
        end
        chk("bp_no_ninth", out_valid, 1'b0);
        chk("bp_done", fetch_done, 1'b1);

        // redirect mid-stream, then from DONE
        reset_dut(1'b1);
        wait_edges(4);
        chk("rd_pc_before", PC, 32'h0C);
        pulse_redirect(32'h40);
        chk("rd_valid_flush", out_valid, 1'b0);
        chk("rd_pc", PC, 32'h40);
        n = 0;
        while (!out_valid && n < 10) begin
            wait_edges(1);
            n++;
        end
        chk("rd_beat_seen", out_valid, 1'b1);
        chk("rd_latency", 32'(n), 32'd2);
        chk("rd_beat_pc", out_pc, 32'h40);
        chk("rd_beat_instr", out_instr, word_of(16));
        pulse_redirect(32'h18);
        n = 0;
        while (!fetch_done && n < 20) begin
            wait_edges(1);
            n++;
        end
        chk("rd_done_set", fetch_done, 1'b1);
        chk("rd_done_pc", PC, 32'h20);
        pulse_redirect(32'h40);
        chk("rd_done_cleared", fetch_done, 1'b0);

        // random traffic against a stream-order reference model
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 19) == 0) ? 32'h0 : ($urandom | 32'h1);
        reset_dut(1'b1);
        exp_pc = 32'h0;
        prev_hold = 1'b0;
        prev_pc = 32'h0;
        prev_instr = 32'h0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (i < 3000) begin
                out_ready = ($urandom_range(0, 3) != 0);
                redirect_valid = ($urandom_range(0, 39) == 0);
                redirect_pc = 32'($urandom_range(0, 255)) << 2;
            end else begin
                out_ready = 1'b1;
                redirect_valid = 1'b0;
            end
            @(negedge clk);
            if (prev_hold) begin
                chk("rnd_hold_valid", out_valid, 1'b1);
                chk("rnd_hold_pc", out_pc, prev_pc);
                chk("rnd_hold_instr", out_instr, prev_instr);
            end
            prev_hold = out_valid && !out_ready && !redirect_valid;
            prev_pc = out_pc;
            prev_instr = out_instr;
            if (redirect_valid) begin
                exp_pc = redirect_pc;
            end else if (out_valid && out_ready) begin
                live = (exp_pc <= 32'h3FC) && (mem[exp_pc[9:2]] != 32'h0);
                chk("rnd_live", live, 1'b1);
                chk("rnd_pc", out_pc, exp_pc);
                chk("rnd_instr", out_instr, mem[exp_pc[9:2]]);
                exp_pc = exp_pc + 32'd4;
            end
            if (i >= 3000 && fetch_done && !out_valid) break;
        end
        chk("rnd_final_done", fetch_done, 1'b1);
        chk("rnd_final_pc", PC, exp_pc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
